// File: rtl/bf_pkg.sv
// Shared defaults, reader FSM state type and FIFO sizing helper for the
// beamformer sum-memory readout path.
package bf_pkg;

  localparam int BF_ADDR_W   = 11;
  localparam int BF_DATA_W   = 12;
  localparam int BF_READ_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BF,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } bf_rd_state_t;

  // Enough room for every read in the latency pipe plus one beat being drained.
  function automatic int fifo_depth(input int read_lat);
    return read_lat + 2;
  endfunction

endpackage

// File: rtl/bf_skid_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is visible on
// rd_data whenever empty is low.
module bf_skid_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bf_sum_reader.sv
// Walks the beamformer sum memory from address 0 to frame_len and streams samples.
// Define BF_READER_PEAK_EN to add the peak_value/peak_index magnitude tracker.
module bf_sum_reader
  import bf_pkg::*;
#(
  parameter int ADDR_W   = BF_ADDR_W,
  parameter int DATA_W   = BF_DATA_W,
  parameter int READ_LAT = BF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_len,
  input  logic              usedataflag,
  input  logic [DATA_W-1:0] output_value,
  output logic              sumouten,
  output logic [ADDR_W-1:0] sumout_address,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output bf_rd_state_t      state_dbg
`ifdef BF_READER_PEAK_EN
  ,
  output logic [DATA_W-1:0] peak_value,
  output logic [ADDR_W-1:0] peak_index
`endif
);

  localparam int DEPTH = fifo_depth(READ_LAT);
  localparam int CNT_W = $clog2(DEPTH + 1);

  bf_rd_state_t      state;
  logic [ADDR_W-1:0] len_q, next_addr;
  logic [READ_LAT:0] pipe_vld, pipe_last;
  logic              issue, issue_last, pop, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   head;
  int                used_slots;

  // Stream: a beat transfers when m_valid && m_ready; once m_valid is high the
  // beat (m_data, m_last) stays put until that handshake happens.
  assign m_valid    = !fifo_empty;
  assign m_data     = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last     = m_valid && head[DATA_W];
  assign pop        = m_valid && m_ready;
  assign issue_last = (next_addr == len_q);
  assign sumouten   = pipe_vld[0];
  assign state_dbg  = state;

  // The beat leaving this cycle frees its slot, which keeps one beat per cycle.
  always_comb begin
    used_slots = $countones(pipe_vld) + int'(fifo_count) - (pop ? 1 : 0);
    issue      = (state == ST_READ) && !usedataflag && (used_slots < DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld  <= {pipe_vld[READ_LAT-1:0], issue};
      pipe_last <= {pipe_last[READ_LAT-1:0], issue && issue_last};
    end
  end

  bf_skid_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pipe_vld[READ_LAT]),
    .wr_data ({pipe_last[READ_LAT], output_value}),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      len_q          <= '0;
      next_addr      <= '0;
      sumout_address <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q     <= frame_len;
            next_addr <= '0;
            busy      <= 1'b1;
            state     <= ST_WAIT_BF;
          end
        end
        ST_WAIT_BF: begin
          if (!usedataflag) state <= ST_READ;
        end
        ST_READ: begin
          if (issue) begin
            sumout_address <= next_addr;
            // Leaving before the increment matters: frame_len may be the top address.
            if (issue_last) state <= ST_DRAIN;
            else next_addr <= next_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (pop && head[DATA_W]) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BF_READER_PEAK_EN
  logic [DATA_W-1:0] mag;
  logic [ADDR_W-1:0] beat_idx;

  assign mag = m_data[DATA_W-1] ? (~m_data + DATA_W'(1)) : m_data;

  // Strictly-greater update keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_value <= '0;
      peak_index <= '0;
      beat_idx   <= '0;
    end else if (state == ST_IDLE && start) begin
      peak_value <= '0;
      peak_index <= '0;
      beat_idx   <= '0;
    end else if (pop) begin
      beat_idx <= beat_idx + ADDR_W'(1);
      if (mag > peak_value) begin
        peak_value <= mag;
        peak_index <= beat_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bf_sum_reader.sv
// Directed bench for bf_sum_reader: BRAM latency model, expected-beat queue
// scoreboard checked every cycle, plus literal per-test expectations.
`timescale 1ns/1ps
module tb_bf_sum_reader;
  import bf_pkg::*;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 12;
  localparam int READ_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              usedataflag = 1'b0;
  logic              m_ready = 1'b0;
  logic [ADDR_W-1:0] frame_len = '0;
  logic [DATA_W-1:0] output_value;
  logic              sumouten, m_valid, m_last, busy, done;
  logic [ADDR_W-1:0] sumout_address;
  logic [DATA_W-1:0] m_data;
  bf_rd_state_t      state_dbg;
`ifdef BF_READER_PEAK_EN
  logic [DATA_W-1:0] peak_value, peak_v_done;
  logic [ADDR_W-1:0] peak_index, peak_i_done;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bf_sum_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .frame_len      (frame_len),
    .usedataflag    (usedataflag),
    .output_value   (output_value),
    .sumouten       (sumouten),
    .sumout_address (sumout_address),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .busy           (busy),
    .done           (done),
    .state_dbg      (state_dbg)
`ifdef BF_READER_PEAK_EN
    ,
    .peak_value     (peak_value),
    .peak_index     (peak_index)
`endif
  );

  // ---------------- sum memory with fixed read latency ----------------
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [ADDR_W-1:0] addr_pipe [READ_LAT];

  always @(posedge clk) begin
    addr_pipe[0] <= sumout_address;
    for (int i = 1; i < READ_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign output_value = mem[addr_pipe[READ_LAT-1]];

  // ---------------- ready driver ----------------
  int ready_mode = 0;
  int rcnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) m_ready = 1'b1;
      else begin
        m_ready = (rcnt % 3 == 0);
        rcnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  logic [DATA_W:0]   exp_q [$];
  logic [DATA_W:0]   exp_beat;
  logic              stall_pending = 1'b0;
  logic              held_last = 1'b0;
  logic [DATA_W-1:0] held_data = '0;
  logic              hs_last_prev = 1'b0;
  logic              udf_prev = 1'b0;
  int                first_issue_cyc = -1;
  int                first_valid_cyc = -1;
  int                last_hs_cyc = 0;
  int                beats_seen = 0;
  logic [DATA_W-1:0] first_beat_data = '0;
  logic [DATA_W-1:0] last_beat_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pending = 1'b0;
      hs_last_prev  = 1'b0;
      udf_prev      = 1'b0;
    end else begin
      chk("done_timing", done, hs_last_prev);
      if (sumouten) begin
        chk("issue_while_bf_busy", udf_prev, 0);
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
      end
      if (stall_pending) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held_data);
        chk("stall_last", m_last, held_last);
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        beats_seen++;
        if (beats_seen == 1) first_beat_data = m_data;
        last_beat_data = m_data;
        last_hs_cyc = cyc;
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_beat = exp_q.pop_front();
          chk("beat_data", m_data, exp_beat[DATA_W-1:0]);
          chk("beat_last", m_last, exp_beat[DATA_W]);
        end
      end
      stall_pending = m_valid && !m_ready;
      held_data     = m_data;
      held_last     = m_last;
      hs_last_prev  = m_valid && m_ready && m_last;
      udf_prev      = usedataflag;
`ifdef BF_READER_PEAK_EN
      if (done) begin
        peak_v_done = peak_value;
        peak_i_done = peak_index;
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [ADDR_W-1:0] len);
    for (int a = 0; a <= int'(len); a++) exp_q.push_back({(a == int'(len)), mem[a]});
    first_issue_cyc = -1;
    first_valid_cyc = -1;
    beats_seen      = 0;
    @(posedge clk);
    #1;
    start     = 1'b1;
    frame_len = len;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_busy_in_done"}, busy, 1);
      @(negedge clk);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_done_one_cycle"}, done, 0);
    end
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_issue(input string tag, input logic [ADDR_W-1:0] addr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sumouten && sumout_address == addr) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_addr_issued"}, seen, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < READ_LAT; i++) addr_pipe[i] = '0;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = DATA_W'(a * 3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sumouten", sumouten, 0);
    chk("rst_address", sumout_address, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: 16 beats of addr*3 with ready always high
    ready_mode = 0;
    start_frame(15);
    wait_done("t1", 200);
    chk("t1_beats", beats_seen, 16);
    chk("t1_first_data", first_beat_data, 0);
    chk("t1_last_data", last_beat_data, 45);
    chk("t1_first_valid_lat", first_valid_cyc - first_issue_cyc, 3);
    chk("t1_burst_span", last_hs_cyc - first_valid_cyc, 15);

    // 2: same frame, ready high one cycle in three
    ready_mode = 1;
    rcnt = 0;
    start_frame(15);
    wait_done("t2", 400);
    chk("t2_beats", beats_seen, 16);
    chk("t2_last_data", last_beat_data, 45);
    ready_mode = 0;

    // 3: beamformer busy at start for 50 cycles
    @(posedge clk);
    #1;
    usedataflag = 1'b1;
    start_frame(15);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t3_no_read_while_busy", sumouten, 0);
    end
    @(posedge clk);
    #1;
    usedataflag = 1'b0;
    wait_done("t3", 200);
    chk("t3_beats", beats_seen, 16);

    // 4: busy pulse after address 7 issued; stream must still be 0..15 once each
    for (int a = 0; a < 16; a++) mem[a] = DATA_W'(a);
    start_frame(15);
    wait_issue("t4", 7);
    @(posedge clk);
    #1;
    usedataflag = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    usedataflag = 1'b0;
    wait_done("t4", 200);
    chk("t4_beats", beats_seen, 16);
    chk("t4_last_data", last_beat_data, 15);

    // 5: reset mid-frame, then a single-beat frame
    for (int a = 0; a < 16; a++) mem[a] = DATA_W'(a * 3);
    start_frame(15);
    wait_issue("t5", 7);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst_sumouten", sumouten, 0);
    chk("t5_rst_address", sumout_address, 0);
    chk("t5_rst_m_valid", m_valid, 0);
    chk("t5_rst_m_data", m_data, 0);
    chk("t5_rst_m_last", m_last, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem[0] = 12'h5A5;
    start_frame(0);
    wait_done("t5", 100);
    chk("t5_beats", beats_seen, 1);
    chk("t5_data", last_beat_data, 12'h5A5);

`ifdef BF_READER_PEAK_EN
    // 6: peak magnitude with {5, -40, 40, 12}
    mem[0] = 12'd5;
    mem[1] = 12'hFD8;
    mem[2] = 12'd40;
    mem[3] = 12'd12;
    start_frame(3);
    wait_done("t6", 100);
    chk("t6_peak_value", peak_v_done, 40);
    chk("t6_peak_index", peak_i_done, 1);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bf_sum_reader.md
# bf_sum_reader

Readout engine for the delay-and-sum beamformer's summed-output BRAM. After a beamforming pass completes, it walks the sum memory from address 0, absorbs the fixed BRAM read latency, and presents each summed sample on a valid/ready stream toward the downstream consumer (UART/host link or FIFO). It drives `sumouten` and `sumout_address` and consumes `output_value` and `usedataflag`, replacing the manual address stepping done during bring-up.

## Interface
- `ADDR_W`, 11, sum-memory address width
- `DATA_W`, 12, summed-sample width
- `READ_LAT`, 2, cycles from `sumout_address` change to valid `output_value`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  one-cycle request to read one frame
- `frame_len`  in  ADDR_W  last address to read, sampled on accepted `start`
- `usedataflag`  in  1  beamformer busy; memory must not be read while high
- `output_value`  in  DATA_W  BRAM read data
- `sumouten`  out  1  read enable to beamformer sum memory
- `sumout_address`  out  ADDR_W  read address
- `m_data`  out  DATA_W  stream data
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready
- `m_last`  out  1  marks sample at address `frame_len`
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after final handshake

## Operation
- States: IDLE, WAIT_BF, READ, DRAIN, DONE.
- IDLE: `start` captures `frame_len`, moves to WAIT_BF. `start` outside IDLE is ignored.
- WAIT_BF: stays while `usedataflag`=1; on `usedataflag`=0 moves to READ with address 0.
- READ: issues one address per cycle when credit is available; credit = FIFO_DEPTH − (in-flight reads + FIFO occupancy), FIFO_DEPTH = READ_LAT+2. Each issue increments address. After issuing `frame_len`, goes to DRAIN.
- DRAIN: waits until in-flight reads are zero and FIFO is empty with last beat accepted, then DONE.
- DONE: `done`=1 for one cycle, return to IDLE.
- Read data returns through a READ_LAT-deep valid shift register tagged with a last bit; writes into skid FIFO; FIFO head drives `m_data`/`m_valid`/`m_last`.
- `usedataflag` rising during READ/DRAIN: issuing halts (no new addresses) until it falls; in-flight data still captured. No data lost or duplicated.
- `frame_len`=0: exactly one beat, `m_last`=1 on it. `frame_len`=2^ADDR_W−1: full memory, address never wraps.
- Stream rules: `m_data`/`m_last` held stable while `m_valid`=1 and `m_ready`=0; `m_valid` never drops without handshake.
- Reset mid-operation: all state, counters, FIFO cleared immediately; no partial frame resumes.

## Timing
- Reset values: `sumouten`=0, `sumout_address`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0.
- `busy`=1 from cycle after accepted `start` through the DONE cycle.
- `sumouten`=1 exactly in cycles that issue an address (registered output).
- First `m_valid` at READ_LAT+1 cycles after first issue with `m_ready` held high.
- Sustained throughput one beat/cycle when `m_ready`=1 and `usedataflag`=0.
- `done` asserts one cycle after handshake of the `m_last` beat.

## Configuration
- `BF_READER_PEAK_EN`: when defined, adds outputs `peak_value` (DATA_W, signed magnitude max of two's-complement samples) and `peak_index` (ADDR_W), updated per handshake, cleared on accepted `start` and reset, valid when `done` pulses; ties keep the lowest index. Undefined: ports and logic absent, core behaviour identical.

## Structure
- Package `bf_pkg`: ADDR_W/DATA_W defaults, state enum `bf_rd_state_t`, FIFO_DEPTH derivation function.
- Sub-module `bf_skid_fifo`: parameterised synchronous FIFO (DATA_W+1 wide, FIFO_DEPTH entries) with count output; reused elsewhere.

## Test plan
- `frame_len`=15, `m_ready`=1, memory holds addr×3 → 16 beats 0,3,…,45 in order, `m_last` on 45, `done` one cycle later.
- Same frame, `m_ready` high 1 cycle in 3 → identical 16-beat sequence, no drop/duplicate, data stable while stalled.
- `usedataflag`=1 at `start` for 50 cycles → `sumouten`=0 throughout; reading begins after fall.
- `usedataflag` pulses high 10 cycles after address 7 issued → issuing pauses, stream still yields 0..15 exactly once.
- `rst_n` low after address 7 → all outputs at reset values next edge; new `start` with `frame_len`=0 yields one beat with `m_last`=1.
- `BF_READER_PEAK_EN` with samples {5, −40, 40, 12} → `peak_value`=40 magnitude, `peak_index`=1.
